// File: rtl/blk_mem_burst_master_if.sv
// Word-wide memory port shared by the burst master and its memory.
interface cnnip_mem_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  en;
  logic [3:0]            we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           din;
  logic [31:0]           dout;
  logic                  valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/blk_mem_burst_master.sv
// Burst master: turns one command into a run of word writes or reads on mem_if_a.
// Optional read-wait timeout is built when BURST_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR      | streaming write words, one access per accepted wdata
// RD_REQ  | issuing a single read request
// RD_WAIT | waiting for the memory to return valid
// RD_OUT  | presenting rdata until the consumer takes it
// FIN     | burst over, done pulses next cycle
module blk_mem_burst_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_a,
  input  logic                  arstz_aq,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [31:0]           wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  cnnip_mem_if.master           mem_if_a
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, FIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  mem_quiet;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  last_word;

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_range_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // No access is ever launched in a cycle where the memory is returning data.
  assign mem_quiet = !mem_if_a.valid;
  assign wready    = (state == WR) && mem_quiet;
  assign wr_fire   = wready && wvalid;
  assign rd_fire   = (state == RD_REQ) && mem_quiet;
  assign last_word = (remaining == LEN_WIDTH'(1));
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign mem_if_a.en   = wr_fire || rd_fire;
  assign mem_if_a.we   = wr_fire ? 4'hF : 4'h0;
  assign mem_if_a.addr = cur_addr;
  assign mem_if_a.din  = wr_fire ? wdata : 32'h0;

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      done      <= 1'b0;
`ifdef BURST_TIMEOUT_EN
      err       <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BURST_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr  <= cmd_addr & ~ADDR_WIDTH'(3);
            remaining <= cmd_len;
            if (cmd_len == '0)  state <= FIN;
            else if (cmd_write) state <= WR;
            else                state <= RD_REQ;
          end
        end
        WR: begin
          if (wr_fire) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(4);
            remaining <= remaining - LEN_WIDTH'(1);
            if (last_word) state <= FIN;
          end
        end
        RD_REQ: begin
          if (rd_fire) begin
            state <= RD_WAIT;
`ifdef BURST_TIMEOUT_EN
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        RD_WAIT: begin
          if (mem_if_a.valid) begin
            rdata  <= mem_if_a.dout;
            rvalid <= 1'b1;
            state  <= RD_OUT;
          end
`ifdef BURST_TIMEOUT_EN
          // Terminal count reached with no response: abandon the rest of the burst.
          else if (tmo_cnt == '0) begin
            done      <= 1'b1;
            err       <= 1'b1;
            remaining <= '0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
`endif
        end
        RD_OUT: begin
          if (rready) begin
            rvalid    <= 1'b0;
            cur_addr  <= cur_addr + ADDR_WIDTH'(4);
            remaining <= remaining - LEN_WIDTH'(1);
            state     <= last_word ? FIN : RD_REQ;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_mem_burst_master.sv
// Scoreboard bench for blk_mem_burst_master against a 3-cycle-latency memory model.
module tb_blk_mem_burst_master;
  localparam int AW  = 10;
  localparam int LW  = 8;
  localparam int TMO = 15;

  logic          clk_a = 1'b0;
  logic          arstz_aq = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [31:0]   wdata = '0, rdata;
  logic          wvalid = 1'b0, wready, rvalid, rready = 1'b0;
  logic          busy, done, err;

  always #5 clk_a = ~clk_a;

  cnnip_mem_if #(.ADDR_WIDTH(AW)) mem_if_a ();

  blk_mem_burst_master #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_a(clk_a), .arstz_aq(arstz_aq),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .busy(busy), .done(done), .err(err),
    .mem_if_a(mem_if_a)
  );

  // Memory model: writes land at the edge, reads return valid 3 cycles after en.
  logic [31:0]   mem [0:255];
  logic [2:0]    rd_pipe = '0;
  logic [AW-1:0] ra0 = '0, ra1 = '0, ra2 = '0;
  logic          mute = 1'b0, stray = 1'b0;

  always @(posedge clk_a) begin
    if (mem_if_a.en && mem_if_a.we == 4'hF) mem[mem_if_a.addr[9:2]] <= mem_if_a.din;
    rd_pipe <= {rd_pipe[1:0], mem_if_a.en && (mem_if_a.we == 4'h0)};
    ra0 <= mem_if_a.addr;
    ra1 <= ra0;
    ra2 <= ra1;
  end
  assign mem_if_a.valid = (rd_pipe[2] && !mute) || stray;
  assign mem_if_a.dout  = mem[ra2[9:2]];

  typedef struct packed {
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  logic [31:0] vec [0:3];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an access, read word or done.
  always @(negedge clk_a) begin
    acc_t        e;
    logic [31:0] d;
    logic        x;
    if (arstz_aq) begin
      if (mem_if_a.en) begin
        check("en_during_valid", {63'd0, mem_if_a.valid}, 64'd0);
        if (exp_acc.size() == 0) fail_now("unexpected_access");
        else begin
          e = exp_acc.pop_front();
          check("acc_we", {60'd0, mem_if_a.we}, {60'd0, e.we});
          check("acc_addr", {54'd0, mem_if_a.addr}, {54'd0, e.addr});
          check("acc_din", {32'd0, mem_if_a.din}, {32'd0, e.din});
        end
      end
      if (rvalid && rready) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rdata");
        else begin
          d = exp_rd.pop_front();
          check("rdata", {32'd0, rdata}, {32'd0, d});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else begin
          x = exp_done.pop_front();
          check("done_err", {63'd0, err}, {63'd0, x});
        end
      end else if (err) begin
        fail_now("err_without_done");
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int b = 0;
    @(posedge clk_a); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && b < 50) begin @(posedge clk_a); #1; b++; end
    if (b >= 50) fail_now("cmd_ready_timeout");
    @(posedge clk_a); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin @(negedge clk_a); cyc++; end while (!done && cyc < 300);
    if (!done) fail_now(name);
  endtask

  task automatic wait_rvalid(input string name);
    int b = 0;
    do begin @(negedge clk_a); b++; end while (!rvalid && b < 50);
    if (!rvalid) fail_now(name);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int n);
    acc_t          e;
    logic [AW-1:0] base;
    int            i, b, cyc;
    logic          ok;
    base = a & ~AW'(3);
    for (int k = 0; k < n; k++) begin
      e.we = 4'hF; e.addr = base + AW'(4 * k); e.din = vec[k];
      exp_acc.push_back(e);
    end
    exp_done.push_back(1'b0);
    wdata = vec[0]; wvalid = 1'b1;
    send_cmd(1'b1, a, LW'(n));
    i = 0; b = 0;
    while (i < n && b < 100) begin
      @(negedge clk_a); ok = wready;
      @(posedge clk_a); #1; b++;
      if (ok) begin i++; if (i < n) wdata = vec[i]; end
    end
    if (i < n) fail_now("write_stream_timeout");
    wvalid = 1'b0;
    wait_done("write_done_timeout", cyc);
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int n);
    acc_t          e;
    logic [AW-1:0] base;
    int            cyc;
    base = a & ~AW'(3);
    for (int k = 0; k < n; k++) begin
      e.we = 4'h0; e.addr = base + AW'(4 * k); e.din = 32'h0;
      exp_acc.push_back(e);
      exp_rd.push_back(vec[k]);
    end
    exp_done.push_back(1'b0);
    rready = 1'b1;
    send_cmd(1'b0, a, LW'(n));
    wait_done("read_done_timeout", cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},     {63'd0, mem_if_a.en}, 64'd0);
    check({tag, "_we"},     {60'd0, mem_if_a.we}, 64'd0);
    check({tag, "_addr"},   {54'd0, mem_if_a.addr}, 64'd0);
    check({tag, "_din"},    {32'd0, mem_if_a.din}, 64'd0);
    check({tag, "_rdata"},  {32'd0, rdata}, 64'd0);
    check({tag, "_rvalid"}, {63'd0, rvalid}, 64'd0);
    check({tag, "_wready"}, {63'd0, wready}, 64'd0);
    check({tag, "_busy"},   {63'd0, busy}, 64'd0);
    check({tag, "_done"},   {63'd0, done}, 64'd0);
    check({tag, "_err"},    {63'd0, err}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    acc_t e;

    #3 arstz_aq = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(negedge clk_a);
    arstz_aq = 1'b1;
    @(negedge clk_a);
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Four-word write starting at 0x010.
    vec[0] = 32'hA5A5_0001; vec[1] = 32'hDEAD_BEEF; vec[2] = 32'h1234_5678; vec[3] = 32'h0BAD_F00D;
    write_burst(10'h010, 4);

    // Read the first three back; byte offset bits in cmd_addr must be ignored.
    read_burst(10'h012, 3);

    // Read two with the consumer stalled.
    e.we = 4'h0; e.din = 32'h0;
    e.addr = 10'h010; exp_acc.push_back(e);
    e.addr = 10'h014; exp_acc.push_back(e);
    exp_rd.push_back(32'hA5A5_0001);
    exp_rd.push_back(32'hDEAD_BEEF);
    exp_done.push_back(1'b0);
    rready = 1'b0;
    send_cmd(1'b0, 10'h010, 2);
    wait_rvalid("stall_rvalid_timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_a);
      check("stall_rvalid", {63'd0, rvalid}, 64'd1);
      check("stall_rdata", {32'd0, rdata}, {32'd0, 32'hA5A5_0001});
      check("stall_no_en", {63'd0, mem_if_a.en}, 64'd0);
    end
    @(posedge clk_a); #1 rready = 1'b1;
    wait_done("stall_done_timeout", cyc);

    // Zero-length command: no access, done two cycles after the handshake.
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 10'h020, 0);
    wait_done("len0_done_timeout", cyc);
    check("len0_done_latency", 64'(cyc), 64'd2);

    // Address wrap at the top of a 10-bit space.
    vec[0] = 32'hCAFE_0000; vec[1] = 32'h0000_FACE;
    write_burst(10'h3FE, 2);
    read_burst(10'h3FC, 2);

    // Stray valid while idle must not start anything.
    @(posedge clk_a); #1 stray = 1'b1;
    @(posedge clk_a); #1 stray = 1'b0;
    @(negedge clk_a);
    check("stray_busy", {63'd0, busy}, 64'd0);
    check("stray_cmd_ready", {63'd0, cmd_ready}, 64'd1);

`ifdef BURST_TIMEOUT_EN
    // Memory never answers: err and done together TMO cycles after RD_WAIT entry.
    mute = 1'b1;
    e.we = 4'h0; e.din = 32'h0; e.addr = 10'h040;
    exp_acc.push_back(e);
    exp_done.push_back(1'b1);
    rready = 1'b1;
    send_cmd(1'b0, 10'h040, 2);
    wait_done("timeout_done_timeout", cyc);
    check("timeout_latency", 64'(cyc), 64'(TMO + 2));
    check("timeout_err", {63'd0, err}, 64'd1);
    repeat (5) @(negedge clk_a);
    check("timeout_idle", {63'd0, busy}, 64'd0);
    mute = 1'b0;
`endif

    // Reset while a read word is being presented.
    e.we = 4'h0; e.din = 32'h0; e.addr = 10'h010;
    exp_acc.push_back(e);
    rready = 1'b0;
    vec[0] = 32'hCAFE_0000;
    send_cmd(1'b0, 10'h010, 2);
    wait_rvalid("midreset_rvalid_timeout");
    @(posedge clk_a); #1 arstz_aq = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(negedge clk_a);
    arstz_aq = 1'b1;
    rready = 1'b1;
    repeat (6) @(negedge clk_a);
    check("midreset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("midreset_busy", {63'd0, busy}, 64'd0);

    repeat (4) @(negedge clk_a);
    check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blk_mem_burst_master.md
BLK_MEM_BURST_MASTER -- requirements
Module: blk_mem_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, byte-address width of mem_if_a.addr.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of the burst word count.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum read wait in cycles; used only under REQ-024.
REQ-004 SHALL have clk_a  in  1  clock; all logic is on its rising edge.
REQ-005 SHALL have arstz_aq  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 SHALL have cmd_write  in  1  direction: 1 = write, 0 = read.
REQ-008 SHALL have cmd_addr  in  ADDR_WIDTH  byte start address; bits [1:0] ignored and treated as 0.
REQ-009 SHALL have cmd_len  in  LEN_WIDTH  word count; 0 means no memory access.
REQ-010 SHALL have wdata/wvalid/wready  in/in/out  32/1/1  write-data stream.
REQ-011 SHALL have rdata/rvalid/rready  out/out/in  32/1/1  read-data stream.
REQ-012 SHALL have busy/done/err  out  1 each; done and err are 1-cycle pulses.
REQ-013 SHALL have mem_if_a  cnnip_mem_if.master: en, we[3:0], addr, din out; dout[31:0], valid in.

Function
REQ-014 SHALL use FSM states IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, FIN.
REQ-015 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready, latch addr (word-aligned), len, and dir; go to FIN if len==0, else WR or RD_REQ.
REQ-016 WR: wready=1. Each wvalid cycle SHALL drive en=1, we=4'hF, addr=cur, din=wdata in that cycle, then add cur+=4 and remaining-=1. Go to FIN after the last word; no wait on valid.
REQ-017 RD_REQ SHALL drive en=1, we=0, addr=cur for exactly one cycle, then enter RD_WAIT.
REQ-018 RD_WAIT SHALL hold en=0 and addr stable. On mem_if_a.valid, capture dout into rdata and enter RD_OUT.
REQ-019 RD_OUT SHALL assert rvalid and hold rdata stable until rready. On handshake, add cur+=4 and remaining-=1, then go to RD_REQ, or to FIN after the last word.
REQ-020 SHALL never assert en in the cycle mem_if_a.valid is high; the minimum gap from valid to the next en is 1 cycle.
REQ-021 FIN SHALL pulse done for 1 cycle, then return to IDLE. busy=1 in every state except IDLE.
REQ-022 SHALL let the address wrap modulo 2^ADDR_WIDTH with no error.
REQ-023 SHALL ignore mem_if_a.valid outside RD_WAIT; a stray valid SHALL NOT change state.

Reset
REQ-025 While arstz_aq=0, SHALL force state IDLE and set all of the following to 0: en, we, addr, din, rdata, rvalid, wready, busy, done, err, counters. cmd_ready SHALL be 1 after release.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately with no further en; the burst is not resumed.

Configuration
REQ-024 With BURST_TIMEOUT_EN defined, a counter SHALL run in RD_WAIT. On reaching TIMEOUT_CYCLES with no valid, the block SHALL pulse err and done together and return to IDLE, discarding the remaining words. Without the macro, there is no counter, err is tied to 0, and RD_WAIT waits indefinitely.

Verification
REQ-027 SHALL write len=4 at addr 0x010 with wvalid held at 1: exactly 4 en/we=F cycles at addrs 0x010, 0x014, 0x018, 0x01C with the matching din, then a done pulse.
REQ-028 SHALL read len=3 at 0x010 against a memory with 3-cycle latency: rdata equals the words written by REQ-027, in order, with exactly one en pulse per word and en=0 during every valid cycle.
REQ-029 SHALL read len=2 with rready held 0 for 5 cycles: rvalid and rdata stay stable, no new en is issued, and the burst completes once rready=1.
REQ-030 SHALL issue cmd_len=0: no en asserted, done pulses 2 cycles after the handshake.
REQ-031 SHALL write len=2 at 0x3FC with ADDR_WIDTH=10: accesses go to 0x3FC then 0x000.
REQ-032 SHALL cover BURST_TIMEOUT_EN with valid never returned: err and done pulse together TIMEOUT_CYCLES after entering RD_WAIT. The bench SHALL also deassert arstz_aq mid-read: all outputs go to 0 immediately.
